inst_fetch: RTL
===============

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage, directly upstream of the instruction memory. Holds the PC, drives
//  the memory word address/read enable, captures returned words into a 2-entry buffer and
//  presents them with their PC to decode over a valid/ready handshake. Also accepts PC
//  redirects from execute (branch/JAL).
// PARAMETERS
//  DW        32     instruction/data width (matches `dw)
//  AW        5      instruction memory word-address width (32 words)
//  RESET_PC  32'h0  byte PC loaded on reset
// PORTS
//  clk_i          in   1    clock; all state on posedge
//  rst_i          in   1    synchronous reset, active-low
//  Imem_addr_o    out  AW   word address to instruction memory = pc[AW+1:2]
//  Imem_rd_en_o   out  1    read enable to instruction memory (combinational)
//  Imem_data_i    in   DW   instruction word from memory
//  Redirect_i     in   1    load Redirect_pc_i into PC, flush buffer
//  Redirect_pc_i  in   32   redirect target, byte address
//  Inst_valid_o   out  1    Inst_o/Pc_o valid for decode
//  Inst_ready_i   in   1    decode accepts when valid && ready
//  Inst_o         out  DW   instruction at head of buffer
//  Pc_o           out  32   byte PC of Inst_o
//  Fetch_err_o    out  1    sticky: misaligned redirect taken
// BEHAVIOUR
//  - Reset (rst_i==0 at posedge): pc<=RESET_PC, state<=BOOT, buffer empty; Inst_valid_o=0,
//    Inst_o=0, Pc_o=0, Fetch_err_o=0, Imem_rd_en_o=0. Reset overrides all other inputs.
//  - States: BOOT -> RUN unconditionally after one cycle (memory contents settle).
//    RUN -> ERR on Redirect_i with Redirect_pc_i[1:0]!=0. ERR is left only by reset.
//  - Memory timing: memory samples addr/rd_en on negedge, updates data on same negedge;
//    a read issued in cycle N is captured at the posedge ending cycle N (1-cycle latency).
//    Memory drives 0 when rd_en low; fetch never captures in a cycle with rd_en low.
//  - Imem_rd_en_o = (state==RUN) && !Redirect_i && (occ<2 || (Inst_valid_o && Inst_ready_i)).
//  - On a captured read: push {pc, Imem_data_i} into buffer, pc<=pc+4 (32-bit wrap).
//    Imem_addr_o follows pc, so address wraps 31->0 while Pc_o keeps incrementing.
//  - Buffer: 2-entry FIFO, in-order, head drives Inst_o/Pc_o; Inst_valid_o = occ!=0.
//    Pop on valid&&ready. Simultaneous push+pop at occ 1 or 2: occupancy unchanged.
//    Never push at occ 2 without pop (guaranteed by rd_en rule); no loss, no duplication.
//    Inst_o/Pc_o hold stable while valid && !ready.
//  - Redirect_i (RUN, aligned): pc<=Redirect_pc_i, buffer flushed (occ<=0), no push, no
//    pop counted that cycle; first redirected instruction valid one cycle later.
//    Redirect_i in BOOT: pc loaded, state still ->RUN. Redirect_i in ERR: ignored.
//  - Redirect misaligned: state<=ERR, Fetch_err_o<=1, buffer flushed, pc unchanged;
//    in ERR rd_en=0, Inst_valid_o=0.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds port Fetch_cnt_o out 32 = number of handshakes
//    (valid&&ready) since reset; reset value 0; wraps at 2^32; flushed entries not counted.
//  IF_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset release, ready=1, mem[i]=W_i -> rd_en first high 1 cycle after release;
//    Inst_o W0,W1,W2.. with Pc_o 0x0,0x4,0x8 on consecutive cycles.
//  2 ready=0 for 5 cycles from steady stream -> occ reaches 2, rd_en=0, Inst_o/Pc_o held;
//    ready=1 -> stream resumes in order, no missing or repeated Pc_o.
//  3 occ=2, Redirect_i=1, Redirect_pc_i=0x10 -> next cycle valid=0; following valid shows
//    Pc_o=0x10, Inst_o=mem[4]; flushed entries never handshake.
//  4 Redirect_pc_i=0x13 -> Fetch_err_o=1 next cycle, valid=0, rd_en=0 for 20 cycles
//    until rst_i=0 clears it.
//  5 RESET_PC=0x7C -> Imem_addr_o 31 then 0; Pc_o 0x7C then 0x80, Inst_o=mem[0].
//  6 rst_i=0 mid-stream with occ=2 -> after that edge all outputs at reset values,
//    Fetch_cnt_o=0 when IF_PERF_CNT_EN defined; after 100 handshakes Fetch_cnt_o=100.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port plus decode handshake and redirect.
// No latency of its own; backpressure is carried by Inst_ready_i toward the fetch side.
interface inst_fetch_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic [AW-1:0] Imem_addr_o;
    logic          Imem_rd_en_o;
    logic [DW-1:0] Imem_data_i;
    logic          Redirect_i;
    logic [31:0]   Redirect_pc_i;
    logic          Inst_valid_o;
    logic          Inst_ready_i;
    logic [DW-1:0] Inst_o;
    logic [31:0]   Pc_o;
    logic          Fetch_err_o;
`ifdef IF_PERF_CNT_EN
    logic [31:0]   Fetch_cnt_o;

    modport master (
        output Imem_addr_o, Imem_rd_en_o, Inst_valid_o, Inst_o, Pc_o, Fetch_err_o, Fetch_cnt_o,
        input  Imem_data_i, Redirect_i, Redirect_pc_i, Inst_ready_i
    );
    modport slave (
        input  Imem_addr_o, Imem_rd_en_o, Inst_valid_o, Inst_o, Pc_o, Fetch_err_o, Fetch_cnt_o,
        output Imem_data_i, Redirect_i, Redirect_pc_i, Inst_ready_i
    );
`else
    modport master (
        output Imem_addr_o, Imem_rd_en_o, Inst_valid_o, Inst_o, Pc_o, Fetch_err_o,
        input  Imem_data_i, Redirect_i, Redirect_pc_i, Inst_ready_i
    );
    modport slave (
        input  Imem_addr_o, Imem_rd_en_o, Inst_valid_o, Inst_o, Pc_o, Fetch_err_o,
        output Imem_data_i, Redirect_i, Redirect_pc_i, Inst_ready_i
    );
`endif
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, imem read issue, 2-entry in-order buffer toward decode, redirects.
// Latency: word visible to decode one cycle after its read; redirect target one cycle later.
// Backpressure: reads stop when the buffer is full and not draining. IF_PERF_CNT_EN adds Fetch_cnt_o.
module inst_fetch #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, ERR} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] dat_q [2];
    logic [DW-1:0] dat_d [2];
    logic [31:0]   epc_q [2];
    logic [31:0]   epc_d [2];
`ifdef IF_PERF_CNT_EN
    logic [31:0]   cnt_q, cnt_d;
`endif

    logic       run, inst_vld, pop, push, misalign;
    logic [1:0] occ_pop;

    always_comb begin
        run      = (state_q == RUN);
        inst_vld = (occ_q != 2'd0);
        pop      = run && inst_vld && bus.Inst_ready_i;
        // A read is only issued if its word has a guaranteed slot at capture time.
        push     = run && !bus.Redirect_i && ((occ_q < 2'd2) || pop);
        misalign = (bus.Redirect_pc_i[1:0] != 2'b00);
        occ_pop  = occ_q - {1'b0, pop};

        state_d = state_q;
        pc_d    = pc_q;
        occ_d   = occ_q;
        dat_d   = dat_q;
        epc_d   = epc_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (bus.Redirect_i) pc_d = bus.Redirect_pc_i;
            end
            RUN: begin
                if (bus.Redirect_i) begin
                    occ_d = 2'd0;
                    if (misalign) state_d = ERR;
                    else          pc_d    = bus.Redirect_pc_i;
                end else begin
                    if (pop) begin
                        dat_d[0] = dat_q[1];
                        epc_d[0] = epc_q[1];
                    end
                    if (push) begin
                        dat_d[occ_pop[0]] = bus.Imem_data_i;
                        epc_d[occ_pop[0]] = pc_q;
                        pc_d              = pc_q + 32'd4;
                    end
                    occ_d = occ_pop + {1'b0, push};
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

`ifdef IF_PERF_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (pop && !bus.Redirect_i) cnt_d = cnt_q + 32'd1;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            occ_q   <= 2'd0;
            dat_q   <= '{default: '0};
            epc_q   <= '{default: '0};
`ifdef IF_PERF_CNT_EN
            cnt_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            occ_q   <= occ_d;
            dat_q   <= dat_d;
            epc_q   <= epc_d;
`ifdef IF_PERF_CNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.Imem_addr_o  = pc_q[AW+1:2];
    assign bus.Imem_rd_en_o = push;
    assign bus.Inst_valid_o = inst_vld;
    assign bus.Inst_o       = inst_vld ? dat_q[0] : '0;
    assign bus.Pc_o         = inst_vld ? epc_q[0] : 32'h0;
    assign bus.Fetch_err_o  = (state_q == ERR);
`ifdef IF_PERF_CNT_EN
    assign bus.Fetch_cnt_o  = cnt_q;
`endif
endmodule
